ntt_result_collector: RTL and testbench

//  Downstream of NTTN. Watches the NTTN control pulses and done/dout, and captures each

---
 rtl/ntt_result_collector.sv | 180 ++++++++++++++++++
 tb/tb_ntt_result_collector.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_result_collector.sv
// Captures NTTN result bursts into ping-pong banks and replays them on a
// valid/ready stream tagged NTT/INTT with an end-of-burst marker.
module ntt_result_collector #(
  parameter int DATA_SIZE  = 16,
  parameter int RING_DEPTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  start_intt,
  input  logic                  done,
  input  logic [DATA_SIZE-1:0]  dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_SIZE-1:0]  m_data,
  output logic [RING_DEPTH-1:0] m_index,
  output logic                  m_last,
  output logic                  m_intt,
  output logic                  busy,
  output logic                  overrun,
  input  logic                  clr_overrun
);

  localparam int RING_SIZE = 1 << RING_DEPTH;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_CAPT = 1'b1;

  logic [DATA_SIZE-1:0] mem_q [0:2*RING_SIZE-1];

  logic [0:0]            state_q, state_d;
  logic                  wr_bank_q, wr_bank_d;
  logic [RING_DEPTH-1:0] wr_addr_q, wr_addr_d;
  logic [1:0]            full_q, full_d;
  logic [1:0]            tag_q, tag_d;
  logic                  mode_q, mode_d;
  logic                  ovr_q, ovr_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [RING_DEPTH-1:0] rd_addr_q, rd_addr_d;
  logic                  rd_done_q, rd_done_d;
  logic                  mv_q, mv_d;
  logic [DATA_SIZE-1:0]  md_q;
  logic [RING_DEPTH-1:0] mi_q, mi_d;
  logic                  ml_q, ml_d;
  logic                  mt_q, mt_d;

  logic       wr_en;
  logic       issue;
  logic       ld;
  logic       free;
  logic       ovr_set;
  logic [1:0] full_eff;

  always_comb begin
    state_d   = state_q;
    wr_bank_d = wr_bank_q;
    wr_addr_d = wr_addr_q;
    tag_d     = tag_q;
    mode_d    = mode_q;
    rd_bank_d = rd_bank_q;
    rd_addr_d = rd_addr_q;
    rd_done_d = rd_done_q;
    mv_d      = mv_q;
    mi_d      = mi_q;
    ml_d      = ml_q;
    mt_d      = mt_q;
    wr_en     = 1'b0;
    ovr_set   = 1'b0;

    if (start_intt)
      mode_d = 1'b1;
    else if (start)
      mode_d = 1'b0;

    // A bank released this edge is already free for an incoming done
    free     = mv_q & m_ready & ml_q;
    full_eff = full_q;
    if (free) begin
      full_eff[rd_bank_q] = 1'b0;
      rd_bank_d = ~rd_bank_q;
      rd_done_d = 1'b0;
    end
    full_d = full_eff;

    unique case (state_q)
      S_IDLE: begin
        if (done) begin
          if (full_eff[wr_bank_q]) begin
            ovr_set = 1'b1;
          end else begin
            state_d          = S_CAPT;
            wr_addr_d        = '0;
            tag_d[wr_bank_q] = mode_q;
          end
        end
      end
      S_CAPT: begin
        wr_en     = 1'b1;
        ovr_set   = done;
        wr_addr_d = wr_addr_q + RING_DEPTH'(1);
        if (&wr_addr_q) begin
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d         = ~wr_bank_q;
          state_d           = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    ovr_d = ovr_set | (ovr_q & ~clr_overrun);

    // Output register advances only when empty or being accepted
    ld    = ~mv_q | m_ready;
    issue = ld & full_q[rd_bank_q] & ~rd_done_q;
    if (ld)
      mv_d = issue;
    if (issue) begin
      mi_d      = rd_addr_q;
      ml_d      = &rd_addr_q;
      mt_d      = tag_q[rd_bank_q];
      rd_addr_d = rd_addr_q + RING_DEPTH'(1);
      if (&rd_addr_q)
        rd_done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem_q[{wr_bank_q, wr_addr_q}] <= dout;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      md_q <= '0;
    else if (issue)
      md_q <= mem_q[{rd_bank_q, rd_addr_q}];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      wr_bank_q <= 1'b0;
      wr_addr_q <= '0;
      full_q    <= '0;
      tag_q     <= '0;
      mode_q    <= 1'b0;
      ovr_q     <= 1'b0;
      rd_bank_q <= 1'b0;
      rd_addr_q <= '0;
      rd_done_q <= 1'b0;
      mv_q      <= 1'b0;
      mi_q      <= '0;
      ml_q      <= 1'b0;
      mt_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_bank_q <= wr_bank_d;
      wr_addr_q <= wr_addr_d;
      full_q    <= full_d;
      tag_q     <= tag_d;
      mode_q    <= mode_d;
      ovr_q     <= ovr_d;
      rd_bank_q <= rd_bank_d;
      rd_addr_q <= rd_addr_d;
      rd_done_q <= rd_done_d;
      mv_q      <= mv_d;
      mi_q      <= mi_d;
      ml_q      <= ml_d;
      mt_q      <= mt_d;
    end
  end

  assign m_valid = mv_q;
  assign m_data  = md_q;
  assign m_index = mi_q;
  assign m_last  = ml_q;
  assign m_intt  = mt_q;
  assign overrun = ovr_q;
  assign busy    = (state_q == S_CAPT) | full_q[0] | full_q[1];

endmodule

// File: tb/tb_ntt_result_collector.sv
// Scoreboard bench for ntt_result_collector: table-driven bursts plus
// hand-written overrun, concurrency and async-reset sequences.
module tb_ntt_result_collector;

  localparam int DW = 16;
  localparam int RD = 10;
  localparam int RS = 1 << RD;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          start_intt;
  logic          done;
  logic [DW-1:0] dout;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [RD-1:0] m_index;
  logic          m_last;
  logic          m_intt;
  logic          busy;
  logic          overrun;
  logic          clr_overrun;

  ntt_result_collector #(.DATA_SIZE(DW), .RING_DEPTH(RD)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_intt (start_intt),
    .done       (done),
    .dout       (dout),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_index    (m_index),
    .m_last     (m_last),
    .m_intt     (m_intt),
    .busy       (busy),
    .overrun    (overrun),
    .clr_overrun(clr_overrun)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [RD-1:0] i;
    logic          l;
    logic          t;
  } word_t;

  typedef struct {
    logic          s;
    logic          si;
    logic [DW-1:0] base;
    int            rmode;
    logic          exp_intt;
  } vec_t;

  word_t exp_q[$];
  int    n_chk  = 0;
  int    n_pass = 0;
  int    rdy_mode = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act === req)
      n_pass++;
    else
      $display("FAIL %s: got %h, required %h", nm, act, req);
  endtask

  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b0;
      endcase
    end
  end

  initial begin
    word_t got;
    word_t prev;
    word_t e;
    logic  prev_stall;
    prev_stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      got = {m_data, m_index, m_last, m_intt};
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall)
          chk("stall_hold", {3'b0, m_valid, got}, {3'b0, 1'b1, prev});
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_word: got %h, required none", got);
          end else begin
            e = exp_q.pop_front();
            chk("word", {4'b0, got}, {4'b0, e});
          end
        end
        prev_stall = m_valid & ~m_ready;
        prev = got;
      end
    end
  end

  task automatic burst(input logic s, input logic si,
                       input logic [DW-1:0] base, input logic tag,
                       input bit push, input int nwords);
    word_t w;
    @(posedge clk); #1;
    start = s;
    start_intt = si;
    @(posedge clk); #1;
    start = 1'b0;
    start_intt = 1'b0;
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
    for (int k = 0; k < nwords; k++) begin
      dout = base + DW'(k);
      if (push) begin
        w.d = base + DW'(k);
        w.i = RD'(k);
        w.l = (k == RS - 1);
        w.t = tag;
        exp_q.push_back(w);
      end
      @(posedge clk); #1;
    end
    dout = '0;
  endtask

  task automatic drain(input string nm);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || busy) && c < 6000) begin
      @(posedge clk);
      c++;
    end
    #1;
    chk({nm, "_queue_empty"}, exp_q.size(), 0);
    chk({nm, "_busy_idle"}, {31'b0, busy}, 0);
  endtask

  task automatic pulse(input logic d, input logic c);
    @(posedge clk); #1;
    done = d;
    clr_overrun = c;
    @(posedge clk); #1;
    done = 1'b0;
    clr_overrun = 1'b0;
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{1'b1, 1'b0, 16'h0000, 0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 16'h0000, 1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 16'h0300, 1, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 16'h0050, 0, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 16'h0400, 0, 1'b1};

    reset = 1'b1;
    start = 1'b0;
    start_intt = 1'b0;
    done = 1'b0;
    dout = '0;
    clr_overrun = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_valid",   {31'b0, m_valid}, 0);
    chk("rst_data",    {16'b0, m_data}, 0);
    chk("rst_index",   {22'b0, m_index}, 0);
    chk("rst_last",    {31'b0, m_last}, 0);
    chk("rst_intt",    {31'b0, m_intt}, 0);
    chk("rst_busy",    {31'b0, busy}, 0);
    chk("rst_overrun", {31'b0, overrun}, 0);

    for (int v = 0; v < 5; v++) begin
      rdy_mode = tbl[v].rmode;
      burst(tbl[v].s, tbl[v].si, tbl[v].base, tbl[v].exp_intt, 1'b1, RS);
      drain("table");
      chk("table_overrun", {31'b0, overrun}, 0);
    end

    // Both banks held full, third burst dropped, clear/set priority
    rdy_mode = 2;
    burst(1'b1, 1'b0, 16'h0100, 1'b0, 1'b1, RS);
    burst(1'b0, 1'b1, 16'h0200, 1'b1, 1'b1, RS);
    burst(1'b1, 1'b0, 16'h0F00, 1'b0, 1'b0, RS);
    chk("drop_overrun", {31'b0, overrun}, 1);
    chk("drop_busy", {31'b0, busy}, 1);
    pulse(1'b0, 1'b1);
    chk("clr_alone", {31'b0, overrun}, 0);
    pulse(1'b1, 1'b1);
    chk("set_beats_clr", {31'b0, overrun}, 1);
    pulse(1'b0, 1'b1);
    chk("clr_after_set", {31'b0, overrun}, 0);
    rdy_mode = 0;
    drain("pingpong");
    chk("pingpong_overrun", {31'b0, overrun}, 0);

    // Second done lands while the first burst drains
    burst(1'b1, 1'b0, 16'h0500, 1'b0, 1'b1, RS);
    burst(1'b0, 1'b1, 16'h0600, 1'b1, 1'b1, RS);
    drain("concurrent");
    chk("concurrent_overrun", {31'b0, overrun}, 0);

    // Async reset mid-capture after 500 words
    rdy_mode = 1;
    burst(1'b1, 1'b0, 16'h0700, 1'b0, 1'b1, 500);
    reset = 1'b1;
    #1;
    chk("arst_valid", {31'b0, m_valid}, 0);
    chk("arst_data",  {16'b0, m_data}, 0);
    chk("arst_busy",  {31'b0, busy}, 0);
    chk("arst_ovr",   {31'b0, overrun}, 0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    rdy_mode = 0;
    burst(1'b0, 1'b1, 16'h0800, 1'b1, 1'b1, RS);
    drain("post_reset");
    chk("post_reset_overrun", {31'b0, overrun}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
